// File: rtl/div3_pkg.sv
// Shared types and constants for the divide-by-3 AN-code encoder and its serial mod-3 residue tracker.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam int DEF_DATA_W = 8;

    // Residue contributed by a set code bit: +1 at even positions, +2 (== -1 mod 3) at odd ones.
    localparam logic [1:0] RES_W1 = 2'd1;
    localparam logic [1:0] RES_W2 = 2'd2;

    function automatic int code_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic logic [1:0] mod3_add(input logic [1:0] r, input logic [1:0] w);
        logic [2:0] t;
        t = {1'b0, r} + {1'b0, w};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

endpackage

// File: rtl/div3_an_encoder_if.sv
// Handshake bundle for the encoder: data-in side, code-out side and the self-check flag.
interface div3_an_encoder_if #(
    parameter int DATA_W = 8
);
    localparam int CODE_W = DATA_W + 2;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              chk_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, chk_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, chk_err
    );
endinterface

// File: rtl/mod3_serial.sv
// Serial mod-3 residue accumulator; i_parity selects weight 2 (odd bit position) instead of 1.
module mod3_serial
    import div3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_bit_en,
    input  logic       i_bit,
    input  logic       i_parity,
    output logic [1:0] o_residue,
    output logic [1:0] o_residue_next
);
    logic [1:0] r_res;
    logic [1:0] w_res_next;

    always_comb begin
        w_res_next = r_res;
        if (i_clr)
            w_res_next = 2'd0;
        else if (i_bit_en && i_bit)
            w_res_next = mod3_add(r_res, i_parity ? RES_W2 : RES_W1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_res <= 2'd0;
        else
            r_res <= w_res_next;
    end

    assign o_residue      = r_res;
    assign o_residue_next = w_res_next;
endmodule

// File: rtl/div3_an_encoder.sv
// Bit-serial AN encoder (A=3): out_code = 3*in_data, computed LSB-first as x + (x<<1).
// Optional residue self-check of the emitted code is built when DIV3_ENC_SELFCHECK_EN is defined.
module div3_an_encoder
    import div3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    div3_an_encoder_if.slave bus
);
    localparam int CODE_W = code_w(DATA_W);
    localparam int CNT_W  = $clog2(CODE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_W - 1);

    enc_state_t        r_state;
    logic [DATA_W-1:0] r_x;
    logic [CODE_W-1:0] r_code;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_carry;
    logic              r_prev;
    logic              r_in_ready;
    logic              r_out_valid;

    logic w_a;
    logic w_s;
    logic w_c_next;
    logic w_accept;
    logic w_last;

    // r_x shifts right each CALC cycle, so bit 0 is x[i] and zero-fills past DATA_W.
    assign w_a      = r_x[0];
    assign w_s      = w_a ^ r_prev ^ r_carry;
    assign w_c_next = (w_a & r_prev) | (w_a & r_carry) | (r_prev & r_carry);
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == CALC) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_code      <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_prev      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x        <= bus.in_data;
                        r_carry    <= 1'b0;
                        r_prev     <= 1'b0;
                        r_cnt      <= CNT_LAST;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_code  <= {w_s, r_code[CODE_W-1:1]};
                    r_carry <= w_c_next;
                    r_prev  <= w_a;
                    r_x     <= {1'b0, r_x[DATA_W-1:1]};
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_code;

`ifdef DIV3_ENC_SELFCHECK_EN
    logic       r_odd;
    logic       r_chk_err;
    logic [1:0] w_residue;
    logic [1:0] w_residue_next;

    mod3_serial u_mod3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (w_accept),
        .i_bit_en       (r_state == CALC),
        .i_bit          (w_s),
        .i_parity       (r_odd),
        .o_residue      (w_residue),
        .o_residue_next (w_residue_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_odd     <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_accept)
                r_odd <= 1'b0;
            else if (r_state == CALC)
                r_odd <= ~r_odd;
            // Sample the residue including the final bit, on the same edge DONE is entered.
            if (w_last)
                r_chk_err <= (w_residue_next != 2'd0);
            else if (r_state == DONE && bus.out_ready)
                r_chk_err <= 1'b0;
        end
    end

    assign bus.chk_err = r_chk_err;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div3_an_encoder.sv
// Directed bench for div3_an_encoder: reset, key vectors, backpressure, mid-run reset, back-to-back, exhaustive.
module tb_div3_an_encoder;
    localparam int DW = 8;
    localparam int CW = DW + 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    div3_an_encoder_if #(.DATA_W(DW)) bus ();

    div3_an_encoder #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic accept_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat counts the accepting edge as edge 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_word();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rel_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [CW-1:0] code;
        int acc_cyc[2];
        logic [CW-1:0] codes[2];
        int na, nc, cyc;
        bit pend;

        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_code", 32'(bus.out_code), 32'd0);
        check_val("rst_chk_err", 32'(bus.chk_err), 32'd0);
        rst_n = 1'b1;

        accept_word(8'h00);
        wait_done(lat);
        check_val("lat_00", 32'(lat), 32'd11);
        check_val("code_00", 32'(bus.out_code), 32'h000);
        check_val("chk_00", 32'(bus.chk_err), 32'd0);
        release_word();

        accept_word(8'h55);
        wait_done(lat);
        check_val("code_55", 32'(bus.out_code), 32'h0FF);
        release_word();

        // Backpressure on the all-ones word; a new offer must be ignored while in DONE.
        bus.out_ready = 1'b1;
        accept_word(8'hFF);
        bus.out_ready = 1'b0;
        wait_done(lat);
        check_val("lat_FF", 32'(lat), 32'd11);
        check_val("code_FF", 32'(bus.out_code), 32'h2FD);
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_code", 32'(bus.out_code), 32'h2FD);
            check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_val("bp_chk", 32'(bus.chk_err), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_word();
        check_val("bp_code_hold", 32'(bus.out_code), 32'h2FD);
        @(negedge clk);
        check_val("bp_idle_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset in the middle of CALC.
        accept_word(8'hA7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("mrst_code", 32'(bus.out_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept_word(8'h03);
        wait_done(lat);
        check_val("code_03", 32'(bus.out_code), 32'h009);
        release_word();

        // Back-to-back with in_valid and out_ready held high.
        na = 0; nc = 0; cyc = 0; pend = 1'b0;
        @(negedge clk);
        bus.in_data   = 8'h01;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (nc < 2 && cyc < 80) begin
            if (pend) begin
                bus.in_data = 8'h02;
                pend = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && na < 2) begin
                acc_cyc[na] = cyc;
                na++;
                pend = (na == 1);
            end
            if (bus.out_valid) begin
                codes[nc] = bus.out_code;
                nc++;
            end
            if (nc < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("b2b_accepts", 32'(na), 32'd2);
        check_val("b2b_codes", 32'(nc), 32'd2);
        check_val("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(CW + 2));
        check_val("b2b_code0", 32'(codes[0]), 32'd3);
        check_val("b2b_code1", 32'(codes[1]), 32'd6);

        for (int d = 0; d < 256; d++) begin
            accept_word(DW'(d));
            wait_done(lat);
            code = bus.out_code;
            check_val("ex_code", 32'(code), 32'(3 * d));
            check_val("ex_mod3", 32'(code) % 3, 32'd0);
            check_val("ex_chk", 32'(bus.chk_err), 32'd0);
            release_word();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
